// File: rtl/rggen_host_if_apb_bridge.sv
// rggen_host_if_apb_bridge
//
// Bridges an APB completer port onto the rggen local register-bus command
// interface. A transfer is captured during the APB setup phase, checked
// against the address window and optional privilege requirement, and then
// either issued as a local command or answered directly with an error. The
// bus response is returned during one RESPONSE cycle with o_pready high.
//
// Ports
//   clk, rst            : clock and synchronous active-high reset
//   i_paddr .. i_pstrb  : APB request (address, protection, select, enable,
//                         direction, write data, byte strobes)
//   o_pready            : one-cycle completion pulse
//   o_prdata, o_pslverr : read data and error flag, valid with o_pready
//   o_command_valid     : local command is being presented
//   o_write, o_read     : local command direction
//   o_address           : window-relative address
//   o_write_data        : captured write data
//   o_write_mask        : byte-expanded strobes (all-ones on reads)
//   i_response_ready    : local side accepts the command and returns status
//   i_read_data         : local read data
//   i_status            : local status, bit 0 flags an error
//
// Every output comes straight from a flop.

module rggen_host_if_apb_bridge #(
  parameter int                            DATA_WIDTH          = 32,
  parameter int                            HOST_ADDRESS_WIDTH  = 16,
  parameter int                            LOCAL_ADDRESS_WIDTH = 16,
  parameter logic [HOST_ADDRESS_WIDTH-1:0] BASE_ADDRESS        = '0,
  parameter int                            TIMEOUT_CYCLES      = 0,
  parameter bit                            PRIVILEGED_ONLY     = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [HOST_ADDRESS_WIDTH-1:0]  i_paddr,
  input  logic [2:0]                     i_pprot,
  input  logic                           i_psel,
  input  logic                           i_penable,
  input  logic                           i_pwrite,
  input  logic [DATA_WIDTH-1:0]          i_pwdata,
  input  logic [DATA_WIDTH/8-1:0]        i_pstrb,
  output logic                           o_pready,
  output logic [DATA_WIDTH-1:0]          o_prdata,
  output logic                           o_pslverr,
  output logic                           o_command_valid,
  output logic                           o_write,
  output logic                           o_read,
  output logic [LOCAL_ADDRESS_WIDTH-1:0] o_address,
  output logic [DATA_WIDTH-1:0]          o_write_data,
  output logic [DATA_WIDTH-1:0]          o_write_mask,
  input  logic                           i_response_ready,
  input  logic [DATA_WIDTH-1:0]          i_read_data,
  input  logic [1:0]                     i_status
);

  localparam int STRB_W = DATA_WIDTH / 8;

  // The counter only has to reach TIMEOUT_CYCLES-1: the cycle that would
  // make it TIMEOUT_CYCLES is the one that leaves COMMAND.
  localparam int                CNT_W            = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int                TIMEOUT_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST     = TIMEOUT_LAST_INT[CNT_W-1:0];

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMAND  = 2'd1,
    ERROR    = 2'd2,
    RESPONSE = 2'd3
  } state_t;

  // Reads always fetch the full word, so their mask ignores the strobes.
  function automatic logic [DATA_WIDTH-1:0] expand_mask(
    input logic [STRB_W-1:0] strb,
    input logic              write
  );
    logic [DATA_WIDTH-1:0] mask;
    mask = '0;
    for (int i = 0; i < STRB_W; i++) begin
      mask[8*i +: 8] = {8{strb[i] | ~write}};
    end
    return mask;
  endfunction

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [LOCAL_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                           pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]          wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]          wmask_q, wmask_d;
  logic                           cmd_valid_q, cmd_valid_d;
  logic                           write_q, write_d;
  logic                           read_q, read_d;
  logic                           pready_q, pready_d;
  logic [DATA_WIDTH-1:0]          prdata_q, prdata_d;
  logic                           pslverr_q, pslverr_d;

  logic setup;
  logic hit;
  logic prot_ok;
  logic timeout_hit;

  assign setup       = i_psel & ~i_penable;
  // Shifting out the local bits compares only the window-select bits; with
  // equal host and local widths both sides shift to zero and always match.
  assign hit         = (i_paddr >> LOCAL_ADDRESS_WIDTH) == (BASE_ADDRESS >> LOCAL_ADDRESS_WIDTH);
  assign prot_ok     = !PRIVILEGED_ONLY || i_pprot[0];
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    pwrite_d    = pwrite_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    cmd_valid_d = 1'b0;
    write_d     = 1'b0;
    read_d      = 1'b0;
    pready_d    = 1'b0;
    prdata_d    = '0;
    pslverr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (setup) begin
          addr_d   = i_paddr[LOCAL_ADDRESS_WIDTH-1:0];
          pwrite_d = i_pwrite;
          wdata_d  = i_pwdata;
          wmask_d  = expand_mask(i_pstrb, i_pwrite);
          if (hit && prot_ok) begin
            state_d     = COMMAND;
            cnt_d       = '0;
            cmd_valid_d = 1'b1;
            write_d     = i_pwrite;
            read_d      = ~i_pwrite;
          end else begin
            state_d = ERROR;
          end
        end
      end
      COMMAND: begin
        // A ready arriving on the timeout cycle still delivers real status.
        if (i_response_ready) begin
          state_d   = RESPONSE;
          pready_d  = 1'b1;
          prdata_d  = pwrite_q ? '0 : i_read_data;
          pslverr_d = i_status[0];
        end else if (timeout_hit) begin
          state_d   = RESPONSE;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end else begin
          cnt_d       = cnt_q + 1'b1;
          cmd_valid_d = 1'b1;
          write_d     = pwrite_q;
          read_d      = ~pwrite_q;
        end
      end
      ERROR: begin
        state_d   = RESPONSE;
        pready_d  = 1'b1;
        pslverr_d = 1'b1;
      end
      RESPONSE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      pwrite_q    <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      cmd_valid_q <= 1'b0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      pready_q    <= 1'b0;
      prdata_q    <= '0;
      pslverr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      pwrite_q    <= pwrite_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      cmd_valid_q <= cmd_valid_d;
      write_q     <= write_d;
      read_q      <= read_d;
      pready_q    <= pready_d;
      prdata_q    <= prdata_d;
      pslverr_q   <= pslverr_d;
    end
  end

  assign o_pready        = pready_q;
  assign o_prdata        = prdata_q;
  assign o_pslverr       = pslverr_q;
  assign o_command_valid = cmd_valid_q;
  assign o_write         = write_q;
  assign o_read          = read_q;
  assign o_address       = addr_q;
  assign o_write_data    = wdata_q;
  assign o_write_mask    = wmask_q;

  // Protection bits 2:1 and status bit 1 carry no meaning for this bridge.
  logic unused_inputs;
  assign unused_inputs = ^{i_pprot[2:1], i_status[1]};

endmodule

// File: tb/tb_rggen_host_if_apb_bridge.sv
// Testbench for rggen_host_if_apb_bridge.
// Two instances share one clock and reset:
//   index 0 : default parameters (16/16 address, no timeout, no privilege check)
//   index 1 : HOST=20, LOCAL=16, BASE=0x30000, TIMEOUT_CYCLES=4, PRIVILEGED_ONLY=1
// Each transfer pushes its expected response onto a queue and pops it when
// o_pready appears.

module tb_rggen_host_if_apb_bridge;

  localparam logic [19:0] B_BASE    = 20'h30000;
  localparam int          B_TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] paddr_a;
  logic [19:0] paddr_b;
  logic [2:0]  pprot      [2];
  logic        psel       [2];
  logic        penable    [2];
  logic        pwrite     [2];
  logic [31:0] pwdata     [2];
  logic [3:0]  pstrb      [2];
  logic        pready     [2];
  logic [31:0] prdata     [2];
  logic        pslverr    [2];
  logic        cmd_valid  [2];
  logic        lwrite     [2];
  logic        lread      [2];
  logic [15:0] laddr      [2];
  logic [31:0] lwdata     [2];
  logic [31:0] lwmask     [2];
  logic        resp_ready [2];
  logic [31:0] rdata      [2];
  logic [1:0]  status     [2];

  rggen_host_if_apb_bridge #(
    .DATA_WIDTH(32), .HOST_ADDRESS_WIDTH(16), .LOCAL_ADDRESS_WIDTH(16)
  ) dut_a (
    .clk(clk), .rst(rst),
    .i_paddr(paddr_a), .i_pprot(pprot[0]), .i_psel(psel[0]), .i_penable(penable[0]),
    .i_pwrite(pwrite[0]), .i_pwdata(pwdata[0]), .i_pstrb(pstrb[0]),
    .o_pready(pready[0]), .o_prdata(prdata[0]), .o_pslverr(pslverr[0]),
    .o_command_valid(cmd_valid[0]), .o_write(lwrite[0]), .o_read(lread[0]),
    .o_address(laddr[0]), .o_write_data(lwdata[0]), .o_write_mask(lwmask[0]),
    .i_response_ready(resp_ready[0]), .i_read_data(rdata[0]), .i_status(status[0])
  );

  rggen_host_if_apb_bridge #(
    .DATA_WIDTH(32), .HOST_ADDRESS_WIDTH(20), .LOCAL_ADDRESS_WIDTH(16),
    .BASE_ADDRESS(B_BASE), .TIMEOUT_CYCLES(B_TIMEOUT), .PRIVILEGED_ONLY(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst),
    .i_paddr(paddr_b), .i_pprot(pprot[1]), .i_psel(psel[1]), .i_penable(penable[1]),
    .i_pwrite(pwrite[1]), .i_pwdata(pwdata[1]), .i_pstrb(pstrb[1]),
    .o_pready(pready[1]), .o_prdata(prdata[1]), .o_pslverr(pslverr[1]),
    .o_command_valid(cmd_valid[1]), .o_write(lwrite[1]), .o_read(lread[1]),
    .o_address(laddr[1]), .o_write_data(lwdata[1]), .o_write_mask(lwmask[1]),
    .i_response_ready(resp_ready[1]), .i_read_data(rdata[1]), .i_status(status[1])
  );

  typedef struct {
    logic [31:0] prdata;
    logic        slverr;
    int          cmd_cycles;
    int          pready_cycle;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic outputs_zero(input int d, input string tag);
    check({tag, "_pready"},    64'(pready[d]),    64'd0);
    check({tag, "_prdata"},    64'(prdata[d]),    64'd0);
    check({tag, "_pslverr"},   64'(pslverr[d]),   64'd0);
    check({tag, "_cmd_valid"}, 64'(cmd_valid[d]), 64'd0);
    check({tag, "_write"},     64'(lwrite[d]),    64'd0);
    check({tag, "_read"},      64'(lread[d]),     64'd0);
    check({tag, "_address"},   64'(laddr[d]),     64'd0);
    check({tag, "_wdata"},     64'(lwdata[d]),    64'd0);
    check({tag, "_wmask"},     64'(lwmask[d]),    64'd0);
  endtask

  task automatic drop_bus(input int d);
    psel[d]       = 1'b0;
    penable[d]    = 1'b0;
    resp_ready[d] = 1'b0;
  endtask

  // rdelay: index of the command cycle (0 = first) on which ready is given;
  // negative means ready is never given.
  task automatic xfer(input int d, input logic [19:0] addr, input logic [2:0] prot,
                      input logic wr, input logic [31:0] wd, input logic [3:0] strb,
                      input int rdelay, input logic [31:0] rd, input logic [1:0] st,
                      input string tag);
    exp_t        e;
    exp_t        got;
    logic        hit, ok, to;
    int          tmo, ncmd;
    logic [31:0] mask;
    bit          done;

    tmo  = (d == 0) ? 0 : B_TIMEOUT;
    hit  = (d == 0) ? 1'b1 : (addr[19:16] == B_BASE[19:16]);
    ok   = hit && ((d == 0) || prot[0]);
    to   = ok && ((rdelay < 0) || ((tmo != 0) && (rdelay >= tmo)));
    e.cmd_cycles   = !ok ? 0 : (to ? tmo : rdelay + 1);
    e.pready_cycle = ((e.cmd_cycles == 0) ? 1 : e.cmd_cycles) + 1;
    e.slverr       = (!ok || to) ? 1'b1 : st[0];
    e.prdata       = (!ok || to || wr) ? 32'h0 : rd;
    mask = '0;
    for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{strb[i]}};
    if (!wr) mask = 32'hFFFF_FFFF;
    sbq.push_back(e);

    // T0: outputs idle, then drive the setup phase
    @(negedge clk);
    check({tag, "_idle_pready"},    64'(pready[d]),    64'd0);
    check({tag, "_idle_cmd_valid"}, 64'(cmd_valid[d]), 64'd0);
    if (d == 0) paddr_a = addr[15:0];
    else        paddr_b = addr;
    pprot[d]   = prot;
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    pwdata[d]  = wd;
    pstrb[d]   = strb;
    rdata[d]   = rd;
    status[d]  = st;

    done = 1'b0;
    ncmd = 0;
    for (int cyc = 1; cyc <= 30 && !done; cyc++) begin
      @(negedge clk);
      if (pready[d] === 1'b1) begin
        got = sbq.pop_front();
        check({tag, "_latency"},    64'(cyc),        64'(got.pready_cycle));
        check({tag, "_cmd_cycles"}, 64'(ncmd),       64'(got.cmd_cycles));
        check({tag, "_prdata"},     64'(prdata[d]),  64'(got.prdata));
        check({tag, "_pslverr"},    64'(pslverr[d]), 64'(got.slverr));
        drop_bus(d);
        done = 1'b1;
      end else begin
        check({tag, "_cmd_valid"},   64'(cmd_valid[d]), 64'(ok && (cyc <= e.cmd_cycles)));
        check({tag, "_prdata_quiet"}, 64'(prdata[d]),   64'd0);
        check({tag, "_slverr_quiet"}, 64'(pslverr[d]),  64'd0);
        if (cmd_valid[d] === 1'b1) ncmd++;
        if (cyc == 1 && ok) begin
          check({tag, "_write"},   64'(lwrite[d]), 64'(wr));
          check({tag, "_read"},    64'(lread[d]),  64'(!wr));
          check({tag, "_address"}, 64'(laddr[d]),  64'(addr[15:0]));
          check({tag, "_wmask"},   64'(lwmask[d]), 64'(mask));
          if (wr) check({tag, "_wdata"}, 64'(lwdata[d]), 64'(wd));
        end
        penable[d]    = 1'b1;
        resp_ready[d] = ok && ((cyc - 1) == rdelay);
      end
    end
    if (!done) begin
      check({tag, "_pready_never"}, 64'(pready[d]), 64'd1);
      void'(sbq.pop_front());
      drop_bus(d);
    end
  endtask

  initial begin
    rst = 1'b1;
    paddr_a = '0;
    paddr_b = '0;
    for (int d = 0; d < 2; d++) begin
      pprot[d] = '0; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      pwdata[d] = '0; pstrb[d] = '0; resp_ready[d] = 1'b0; rdata[d] = '0; status[d] = '0;
    end
    repeat (3) @(negedge clk);
    outputs_zero(0, "reset_a");
    outputs_zero(1, "reset_b");
    rst = 1'b0;

    // default instance
    xfer(0, 20'h00010, 3'b000, 1'b1, 32'hDEAD_BEEF, 4'b0101, 0, 32'h0,        2'b00, "a_write");
    xfer(0, 20'h00020, 3'b000, 1'b0, 32'h0,        4'b0000, 3, 32'h1234_5678, 2'b00, "a_read");
    xfer(0, 20'h0FFFC, 3'b000, 1'b0, 32'h0,        4'b1111, 0, 32'hAAAA_5555, 2'b01, "a_read_err");
    xfer(0, 20'h00004, 3'b000, 1'b1, 32'h0102_0304, 4'b1010, 1, 32'hFFFF_FFFF, 2'b01, "a_write_err");

    // windowed / timeout / privileged instance
    xfer(1, 20'h40004, 3'b001, 1'b0, 32'h0,        4'b0000, 0,  32'h5A5A_5A5A, 2'b00, "b_miss");
    xfer(1, 20'h30008, 3'b001, 1'b0, 32'h0,        4'b0000, -1, 32'h7777_7777, 2'b00, "b_timeout");
    xfer(1, 20'h3000C, 3'b001, 1'b0, 32'h0,        4'b0000, 3,  32'h0BAD_F00D, 2'b00, "b_ready_last");
    xfer(1, 20'h3000C, 3'b001, 1'b0, 32'h0,        4'b0000, 3,  32'h0BAD_F00D, 2'b01, "b_ready_last_err");
    xfer(1, 20'h30010, 3'b000, 1'b1, 32'h1111_2222, 4'b1111, 0, 32'h0,        2'b00, "b_unpriv");
    xfer(1, 20'h30010, 3'b001, 1'b1, 32'h1111_2222, 4'b0011, 0, 32'h0,        2'b00, "b_priv");

    // reset while a command is outstanding
    @(negedge clk);
    paddr_b = 20'h30020; pprot[1] = 3'b001; pwrite[1] = 1'b0; pstrb[1] = 4'b0000;
    psel[1] = 1'b1; penable[1] = 1'b0;
    @(negedge clk);
    check("rst_mid_cmd_valid", 64'(cmd_valid[1]), 64'd1);
    penable[1] = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    outputs_zero(1, "rst_mid");
    rst = 1'b0;
    drop_bus(1);
    @(negedge clk);
    check("rst_mid_no_pready", 64'(pready[1]), 64'd0);
    xfer(1, 20'h30024, 3'b001, 1'b0, 32'h0, 4'b0000, 1, 32'hCAFE_0001, 2'b00, "b_after_rst");

    @(negedge clk);
    check("final_pready_a", 64'(pready[0]), 64'd0);
    check("final_pready_b", 64'(pready[1]), 64'd0);
    check("final_sb_empty", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rggen_host_if_apb_bridge.md
RGGEN_HOST_IF_APB_BRIDGE -- requirements
Module: rggen_host_if_apb_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: APB and local data width; multiple of 8.
REQ-002 SHALL have parameter HOST_ADDRESS_WIDTH, default 16: PADDR width.
REQ-003 SHALL have parameter LOCAL_ADDRESS_WIDTH, default 16: register-block address width; at most HOST_ADDRESS_WIDTH.
REQ-004 SHALL have parameter BASE_ADDRESS, default 0: window base; only bits above LOCAL_ADDRESS_WIDTH are compared.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 0: cycles to wait for i_response_ready; 0 disables timeout.
REQ-006 SHALL have parameter PRIVILEGED_ONLY, default 0: 1 rejects accesses with i_pprot[0]=0.
REQ-007 SHALL have ports: clk input 1 clock; rst input 1 reset, synchronous and active-high.
REQ-008 SHALL have APB ports: i_paddr in HOST_ADDRESS_WIDTH; i_pprot in 3; i_psel in 1; i_penable in 1; i_pwrite in 1; i_pwdata in DATA_WIDTH; i_pstrb in DATA_WIDTH/8; o_pready out 1; o_prdata out DATA_WIDTH; o_pslverr out 1.
REQ-009 SHALL have local ports: o_command_valid out 1; o_write out 1; o_read out 1; o_address out LOCAL_ADDRESS_WIDTH; o_write_data out DATA_WIDTH; o_write_mask out DATA_WIDTH; i_response_ready in 1; i_read_data in DATA_WIDTH; i_status in 2 (bit0 = error).

Function
REQ-010 SHALL implement FSM states IDLE, COMMAND, ERROR, RESPONSE; every output is driven from registers.
REQ-011 IDLE: on i_psel=1 and i_penable=0 (setup phase), SHALL capture paddr, pwrite, pwdata and pstrb.
REQ-012 Hit rule: i_paddr[HOST-1:LOCAL] equals BASE_ADDRESS[HOST-1:LOCAL]; always a hit when HOST_ADDRESS_WIDTH equals LOCAL_ADDRESS_WIDTH.
REQ-013 From IDLE, SHALL go to COMMAND on a hit that passes the protection check; otherwise SHALL go to ERROR.
REQ-014 COMMAND: o_command_valid=1; o_write=captured pwrite; o_read=~captured pwrite; o_address=captured paddr[LOCAL-1:0].
REQ-015 o_write_mask SHALL expand each pstrb bit to 8 bits for writes, and SHALL be all-ones for reads regardless of pstrb.
REQ-016 COMMAND: on i_response_ready=1, SHALL register i_read_data (reads only; writes register 0) and i_status[0], then go to RESPONSE.
REQ-017 Timeout counter SHALL clear on COMMAND entry and increment each cycle in COMMAND without ready; reaching TIMEOUT_CYCLES (nonzero) SHALL go to RESPONSE with slverr=1 and prdata=0.
REQ-018 i_response_ready and timeout in the same cycle: ready SHALL win.
REQ-019 ERROR SHALL last 1 cycle with o_command_valid=0, then go to RESPONSE with slverr=1 and prdata=0.
REQ-020 RESPONSE SHALL assert o_pready=1 for exactly 1 cycle with registered o_prdata/o_pslverr, then return to IDLE.
REQ-021 o_pready, o_pslverr and o_prdata SHALL be 0 outside RESPONSE.
REQ-022 Latency: setup at T0, o_command_valid at T1; ready at T1 gives o_pready at T2; an error access gives o_pready at T2.
REQ-023 Dropping i_psel mid-transfer is a protocol violation: the block SHALL complete the command and ignore APB inputs until back in IDLE.
REQ-024 A setup phase in the cycle RESPONSE returns to IDLE SHALL not be missed: IDLE samples it in the next cycle, since APB holds setup for at least 1 cycle.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, clear the counter and capture registers, and drive all outputs 0 (o_read 0), including mid-COMMAND (command dropped, no o_pready).

Verification
REQ-026 Write, DATA_WIDTH=32, paddr 0x0010, pwdata 0xDEADBEEF, pstrb 0b0101, ready at T1 -> command_valid at T1, write_mask 0x00FF00FF, pready=1 slverr=0 at T2.
REQ-027 Read, pstrb 0, ready after 3 cycles with read_data 0x12345678, status 0 -> write_mask 0xFFFFFFFF, prdata 0x12345678 with pready 1 cycle after ready.
REQ-028 HOST=20, LOCAL=16, BASE=0x30000, paddr 0x40004 -> command_valid never asserted, pready=1 with slverr=1, prdata=0 at T2.
REQ-029 TIMEOUT_CYCLES=4, ready never asserted -> command_valid for 4 cycles, then pready with slverr=1; same test with ready on the 4th cycle -> slverr=status[0].
REQ-030 PRIVILEGED_ONLY=1, pprot=0b000 -> error response; pprot=0b001 -> normal access; rst pulsed mid-COMMAND -> all outputs 0 the next cycle, and the next access completes normally.
